// File: rtl/bram_sched_pkg.sv
// bram_sched_pkg
// Shared definitions for the block-organised BRAM ring scheduler.
//   - Default geometry (block count / words per block / word width).
//   - Derived sizes: BLOCK_INDEX (BRAM address width), BLOCK_SIZE (words per block).
//   - Reader FSM state encoding.
//   - Helpers so modules with non-default geometry derive the same widths.
package bram_sched_pkg;

    localparam int unsigned DEF_BLOCK_NUM_INDEX   = 6;
    localparam int unsigned DEF_BLOCK_DEPTH_INDEX = 9;
    localparam int unsigned DEF_BLOCK_WIDTH       = 256;

    // Full BRAM address is {block, word}.
    localparam int unsigned BLOCK_INDEX = DEF_BLOCK_NUM_INDEX + DEF_BLOCK_DEPTH_INDEX;
    localparam int unsigned BLOCK_SIZE  = 2 ** DEF_BLOCK_DEPTH_INDEX;

    // Block length ranges 1..2**DEPTH, so it needs one bit more than a word index.
    localparam int unsigned LEN_WIDTH = DEF_BLOCK_DEPTH_INDEX + 1;

    typedef enum logic [0:0] {
        RdIdle,
        RdStream
    } rd_state_e;

    function automatic int unsigned block_index(input int unsigned num_index,
                                                input int unsigned depth_index);
        return num_index + depth_index;
    endfunction

    function automatic int unsigned len_width(input int unsigned depth_index);
        return depth_index + 1;
    endfunction

endpackage

// File: rtl/bram_block_len_table.sv
// bram_block_len_table
// Per-block committed-length register file: 2**NumIndex entries of LenWidth bits.
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable (block commit)
//   waddr_i  block being committed
//   wdata_i  committed length (1..2**DEPTH)
//   raddr_i  block the reader is about to drain
//   rdata_o  combinational read of raddr_i
// Contents are not reset: an entry is always written before its block is readable.
module bram_block_len_table
    import bram_sched_pkg::*;
#(
    parameter int unsigned NumIndex = DEF_BLOCK_NUM_INDEX,
    parameter int unsigned LenWidth = len_width(DEF_BLOCK_DEPTH_INDEX)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [NumIndex-1:0] waddr_i,
    input  logic [LenWidth-1:0] wdata_i,
    input  logic [NumIndex-1:0] raddr_i,
    output logic [LenWidth-1:0] rdata_o
);

    logic [LenWidth-1:0] len_q [2**NumIndex];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            len_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = len_q[raddr_i];

endmodule

// File: rtl/bram_block_scheduler.sv
// bram_block_scheduler
// Ring-buffer controller for a block-organised BRAM. The producer side packs one
// window per block (closing on in_last or on the final slot); the consumer side
// drains committed blocks in FIFO order as framed word streams.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_valid/in_ready/in_data     producer word handshake
//   in_last                       close current block after this word
//   out_valid/out_ready/out_data  consumer word handshake (out_data = bram_rdata)
//   out_last                      final word of the block being drained
//   out_block                     index of the block being drained
//   used_blocks                   committed, not yet released block count
//   bram_wen/bram_wdata/bram_waddr  BRAM write port, address {wr_blk, wr_word}
//   bram_raddr/bram_rdata         BRAM combinational read port, address {rd_blk, rd_word}
module bram_block_scheduler
    import bram_sched_pkg::*;
#(
    parameter int unsigned BLOCK_NUM_INDEX   = DEF_BLOCK_NUM_INDEX,
    parameter int unsigned BLOCK_DEPTH_INDEX = DEF_BLOCK_DEPTH_INDEX,
    parameter int unsigned BLOCK_WIDTH       = DEF_BLOCK_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [BLOCK_WIDTH-1:0]                       in_data,
    input  logic                                         in_last,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [BLOCK_WIDTH-1:0]                       out_data,
    output logic                                         out_last,
    output logic [BLOCK_NUM_INDEX-1:0]                   out_block,
    output logic [BLOCK_NUM_INDEX:0]                     used_blocks,
    output logic                                         bram_wen,
    output logic [BLOCK_WIDTH-1:0]                       bram_wdata,
    output logic [block_index(BLOCK_NUM_INDEX, BLOCK_DEPTH_INDEX)-1:0] bram_waddr,
    output logic [block_index(BLOCK_NUM_INDEX, BLOCK_DEPTH_INDEX)-1:0] bram_raddr,
    input  logic [BLOCK_WIDTH-1:0]                       bram_rdata
);

    localparam int unsigned NumW = BLOCK_NUM_INDEX;
    localparam int unsigned DepW = BLOCK_DEPTH_INDEX;
    localparam int unsigned LenW = len_width(BLOCK_DEPTH_INDEX);
    localparam int unsigned CntW = BLOCK_NUM_INDEX + 1;

    localparam logic [CntW-1:0] NumBlocks = {1'b1, {NumW{1'b0}}};
    localparam logic [DepW-1:0] LastWord  = '1;

    // Write side
    logic [NumW-1:0] wr_blk_q;
    logic [DepW-1:0] wr_word_q;
    logic            accept;
    logic            commit;
    logic [LenW-1:0] commit_len;

    // Read side
    rd_state_e       state_q;
    logic [NumW-1:0] rd_blk_q;
    logic [DepW-1:0] rd_word_q;
    logic [LenW-1:0] rd_len_q;
    logic [LenW-1:0] tbl_rdata;
    logic            out_valid_q;
    logic            last_word;
    logic            release_blk;

    logic [CntW-1:0] used_q;

    // Ring invariant: wr_blk_q is free exactly when the ring is not full.
    assign in_ready   = (used_q < NumBlocks);
    assign accept     = in_valid & in_ready;
    // in_last on the final slot is one commit, not two.
    assign commit     = accept & (in_last | (wr_word_q == LastWord));
    assign commit_len = {1'b0, wr_word_q} + LenW'(1);

    assign bram_wen   = accept;
    assign bram_wdata = in_data;
    assign bram_waddr = {wr_blk_q, wr_word_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_blk_q  <= '0;
            wr_word_q <= '0;
        end else if (accept) begin
            if (commit) begin
                wr_blk_q  <= wr_blk_q + NumW'(1);
                wr_word_q <= '0;
            end else begin
                wr_word_q <= wr_word_q + DepW'(1);
            end
        end
    end

    bram_block_len_table #(
        .NumIndex (NumW),
        .LenWidth (LenW)
    ) u_len_table (
        .clk_i   (clk),
        .we_i    (commit),
        .waddr_i (wr_blk_q),
        .wdata_i (commit_len),
        .raddr_i (rd_blk_q),
        .rdata_o (tbl_rdata)
    );

    assign last_word   = out_valid_q & ({1'b0, rd_word_q} == (rd_len_q - LenW'(1)));
    assign release_blk = out_valid_q & out_ready & last_word;

    // Reader FSM: out_valid is registered and is high exactly in RdStream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RdIdle;
            rd_blk_q    <= '0;
            rd_word_q   <= '0;
            rd_len_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                RdIdle: begin
                    if (used_q != '0) begin
                        rd_word_q   <= '0;
                        rd_len_q    <= tbl_rdata;
                        out_valid_q <= 1'b1;
                        state_q     <= RdStream;
                    end
                end
                RdStream: begin
                    if (out_ready) begin
                        if (last_word) begin
                            rd_blk_q    <= rd_blk_q + NumW'(1);
                            out_valid_q <= 1'b0;
                            state_q     <= RdIdle;
                        end else begin
                            rd_word_q <= rd_word_q + DepW'(1);
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= RdIdle;
                end
            endcase
        end
    end

    // Commit and release on the same edge cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= '0;
        end else begin
            unique case ({commit, release_blk})
                2'b10:   used_q <= used_q + CntW'(1);
                2'b01:   used_q <= used_q - CntW'(1);
                default: used_q <= used_q;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_last    = last_word;
    assign out_data    = bram_rdata;
    assign out_block   = rd_blk_q;
    assign bram_raddr  = {rd_blk_q, rd_word_q};
    assign used_blocks = used_q;

endmodule

// File: tb/tb_bram_block_scheduler.sv
// Testbench for bram_block_scheduler with 4 blocks x 8 words x 32 bits and an
// inline behavioural BRAM (synchronous write, combinational read).
module tb_bram_block_scheduler;

    localparam int unsigned Num   = 2;
    localparam int unsigned Depth = 3;
    localparam int unsigned Width = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_data;
    logic             out_last;
    logic [Num-1:0]   out_block;
    logic [Num:0]     used_blocks;
    logic             bram_wen;
    logic [Width-1:0] bram_wdata;
    logic [Num+Depth-1:0] bram_waddr;
    logic [Num+Depth-1:0] bram_raddr;
    logic [Width-1:0] bram_rdata;

    always #5 clk = ~clk;

    bram_block_scheduler #(
        .BLOCK_NUM_INDEX   (Num),
        .BLOCK_DEPTH_INDEX (Depth),
        .BLOCK_WIDTH       (Width)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_block   (out_block),
        .used_blocks (used_blocks),
        .bram_wen    (bram_wen),
        .bram_wdata  (bram_wdata),
        .bram_waddr  (bram_waddr),
        .bram_raddr  (bram_raddr),
        .bram_rdata  (bram_rdata)
    );

    // Behavioural BRAM
    logic [Width-1:0] mem [2**(Num+Depth)];
    always @(posedge clk) begin
        if (bram_wen) mem[bram_waddr] <= bram_wdata;
    end
    assign bram_rdata = mem[bram_raddr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [Width-1:0] data;
        logic             last;
        logic [Num-1:0]   blk;
    } exp_t;

    exp_t sb[$];

    // Write-side reference: where the next accepted word must land.
    logic [Num-1:0]   wr_blk_m  = '0;
    logic [Depth-1:0] wr_word_m = '0;

    // Output monitor: compares the head entry whenever a word is presented,
    // so stalled cycles also prove the output holds the expected word.
    always @(negedge clk) begin
        exp_t e;
        check("used_bound", 64'(used_blocks <= 3'd4), 64'd1);
        if (!rst && out_valid) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb[0];
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_last", 64'(out_last), 64'(e.last));
                check("out_block", 64'(out_block), 64'(e.blk));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_word(input logic [Width-1:0] d, input logic l);
        int   waited;
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                check("push_timeout_in_ready", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        check("bram_waddr", 64'(bram_waddr), 64'({wr_blk_m, wr_word_m}));
        check("bram_wen", 64'(bram_wen), 64'd1);
        e.data = d;
        e.last = l | (wr_word_m == 3'd7);
        e.blk  = wr_blk_m;
        sb.push_back(e);
        if (e.last) begin
            wr_blk_m  = wr_blk_m + 2'd1;
            wr_word_m = '0;
        end else begin
            wr_word_m = wr_word_m + 3'd1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && used_blocks == '0 && !out_valid) break;
        end
        check({tag, "_used"}, 64'(used_blocks), 64'd0);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_used", 64'(used_blocks), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_wen", 64'(bram_wen), 64'd0);
        check("rst_waddr", 64'(bram_waddr), 64'd0);
        check("rst_raddr", 64'(bram_raddr), 64'd0);
        @(posedge clk);
        #1;

        // Full block closed by the final slot
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i), 1'b0);
        wait_drain("full");

        // Short block closed by in_last
        push_word(32'h20, 1'b0);
        push_word(32'h21, 1'b0);
        push_word(32'h22, 1'b1);
        wait_drain("short");

        // Fill the ring with one-word blocks while the consumer stalls
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h30 + 32'(i), 1'b1);
        @(negedge clk);
        check("ring_used_full", 64'(used_blocks), 64'd4);
        check("ring_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'h34;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ring_stall_wen", 64'(bram_wen), 64'd0);
            check("ring_stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_word(32'h34, 1'b1);
        wait_drain("ring");

        // Commit on the same edge as a release
        push_word(32'h40, 1'b1);
        push_word(32'h41, 1'b1);
        push_word(32'h42, 1'b1);
        @(negedge clk);
        check("simul_used", 64'(used_blocks), 64'd2);
        @(posedge clk);
        #1;
        wait_drain("simul");

        // Backpressure pattern 1,0,0,1 during a block
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h50 + 32'(i), 1'b0);
        pat = 4'b1001;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            out_ready = pat[i % 4];
            if (sb.size() == 0) break;
        end
        out_ready = 1'b1;
        wait_drain("bp");

        // Reset while streaming at rd_word=4 with a partial block being written
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h60 + 32'(i), 1'b0);
        push_word(32'h68, 1'b0);
        push_word(32'h69, 1'b0);
        @(negedge clk);
        check("mid_out_valid", 64'(out_valid), 64'd1);
        check("mid_raddr0", 64'(bram_raddr), 64'({2'd3, 3'd0}));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("mid_raddr4", 64'(bram_raddr), 64'({2'd3, 3'd4}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        wr_blk_m  = '0;
        wr_word_m = '0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_used", 64'(used_blocks), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_waddr", 64'(bram_waddr), 64'd0);
        check("mid_rst_raddr", 64'(bram_raddr), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_word(32'h70, 1'b0);
        push_word(32'h71, 1'b1);
        wait_drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bram_block_scheduler.md
Name: bram_block_scheduler

Overview:
Ring-buffer controller that sequences the block-organised simulation BRAM (2**BLOCK_NUM_INDEX blocks x 2**BLOCK_DEPTH_INDEX words) for the ThresholdCutter datapath. A producer streams cut windows (valid/ready, optional early `in_last`), which are packed one window per block. A consumer drains committed blocks in FIFO order as framed word streams. The block owns all BRAM write and read address generation plus the per-block length bookkeeping.

Parameters:
BLOCK_NUM_INDEX, 6, log2 of block count (64 blocks)
BLOCK_DEPTH_INDEX, 9, log2 of words per block (512)
BLOCK_WIDTH, 256, word width in bits; matches the BRAM data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  producer word valid
in_ready  out  1  producer word accepted when in_valid&in_ready
in_data  in  BLOCK_WIDTH  producer word
in_last  in  1  closes the current block after this word (early window end)
out_valid  out  1  consumer word valid
out_ready  in  1  consumer accepts word
out_data  out  BLOCK_WIDTH  consumer word (= bram_rdata)
out_last  out  1  final word of the current block
out_block  out  BLOCK_NUM_INDEX  index of the block being drained
used_blocks  out  BLOCK_NUM_INDEX+1  committed, unreleased block count
bram_wen  out  1  BRAM write enable
bram_wdata  out  BLOCK_WIDTH  BRAM write data (= in_data)
bram_waddr  out  NUM+DEPTH idx  {wr_blk, wr_word}
bram_raddr  out  NUM+DEPTH idx  {rd_blk, rd_word}
bram_rdata  in  BLOCK_WIDTH  BRAM combinational read data

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - wr_blk, wr_word, rd_blk, rd_word and used_blocks are 0.
  - Reader FSM goes to IDLE.
  - out_valid=0, out_last=0, bram_wen=0.
  - The length table need not be cleared.
  - BRAM contents are not cleared; all data in flight is discarded.
  - A reset asserted mid-stream aborts both sides with no partial commit.
- Write side (no FSM):
  - in_ready = (used_blocks < 2**BLOCK_NUM_INDEX). Ring invariant: wr_blk is free exactly when the ring is not full.
  - bram_wen = in_valid & in_ready, combinational. bram_waddr = {wr_blk, wr_word}.
  - On each accept: wr_word++.
  - Commit when in_last=1 or wr_word == 2**DEPTH-1:
    - len[wr_blk] <= wr_word+1 (DEPTH+1 bits; range 1..2**DEPTH).
    - wr_blk++ (wraps modulo block count); wr_word <= 0; used_blocks increments.
  - A 1-word block (in_last on the first word) is legal. in_last on the final slot is a single commit, not two.
- Read FSM:
  - IDLE:
    - out_valid=0.
    - If used_blocks > 0: rd_word <= 0, latch rd_len <= len[rd_blk], go to STREAM.
    - A block committed at edge N enters STREAM at edge N+1; its first word is valid in cycle N+1..N+2.
  - STREAM:
    - out_valid=1. bram_raddr = {rd_blk, rd_word}; out_data = bram_rdata (zero added latency).
    - out_last = (rd_word == rd_len-1). out_block = rd_blk.
    - On handshake without last: rd_word++.
    - On handshake with last: rd_blk++ (wraps), used_blocks decrements, go to IDLE. There is one bubble cycle between blocks.
    - out_valid, out_data, out_last and out_block hold stable while out_ready=0.
- Simultaneous commit and release in the same cycle: used_blocks is unchanged.
- used_blocks never exceeds 2**NUM and never underflows. A bench assertion checks both.
- Read-after-write: only committed blocks are readable, so a block is never read while it is being written.

Decomposition:
- Shared package bram_sched_pkg holds:
  - localparams BLOCK_INDEX = NUM+DEPTH and BLOCK_SIZE.
  - Reader FSM state encoding (IDLE, STREAM).
  - Length field width DEPTH+1.
- Sub-module bram_block_len_table: 2**NUM x (DEPTH+1) register file with one synchronous write port (commit) and one combinational read port (rd_blk).
- Top module instantiates the table. It connects to sim_bram externally and does not instantiate it.

Test Plan:
(bench params NUM=2, DEPTH=3: 4 blocks x 8 words; sim_bram attached)
- Full block: 8 words 0x10..0x17, in_last never asserted, out_ready=1 -> commit after word 8; out stream 0x10..0x17, out_last only on 0x17, out_block=0, used_blocks returns to 0.
- Short block: 3 words, in_last on the 3rd -> out_last on the 3rd word, len=3; next window is written at waddr {1,0}.
- Full ring: out_ready=0, write 4 one-word blocks -> used_blocks=4, in_ready=0. A 5th word stalls with bram_wen=0 and in_ready=0. Raising out_ready releases block 0, after which in_ready=1 and writing resumes at wr_blk=0 (wrap).
- Simultaneous commit and release: time a commit on the same edge as a last handshake -> used_blocks unchanged (e.g. stays 1).
- Backpressure: toggle out_ready 1,0,0,1 mid-block -> out_data and out_last stable while stalled; no word is lost or duplicated.
- Mid-stream reset: rst for 1 cycle while STREAM is at rd_word=4 -> next cycle out_valid=0, used_blocks=0, in_ready=1, waddr=0.
